// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage constants: default widths, reset PC, PC stride and counter sizing.
package if_fetch_unit_pkg;

  localparam int unsigned ADDR_WIDTH_DEF  = 32;
  localparam int unsigned INSTR_WIDTH_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam int unsigned PC_INCR         = 4;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant + in-order response channel.
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF
);

  logic                   req;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   gnt;
  logic                   rvalid;
  logic [INSTR_WIDTH-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} fetch entries; clear overrides push/pop.
module if_fetch_unit_fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  input  logic                        clear,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_w(DEPTH)-1:0]     count,
  output logic [WIDTH-1:0]            head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_w(DEPTH);
  localparam logic [CntW-1:0] DepthC = DEPTH[CntW-1:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: the head is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests under a credit limit,
// queues returned words with their PCs and drops responses that were in flight across a redirect.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned          INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned          FIFO_DEPTH  = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEF[ADDR_WIDTH-1:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   if_id_write,
  if_fetch_unit_if.master        imem,
  output logic                   fetch_valid,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic [INSTR_WIDTH-1:0] instr_out
);

  localparam int unsigned CntW   = cnt_w(FIFO_DEPTH);
  localparam int unsigned EntryW = ADDR_WIDTH + INSTR_WIDTH;
  localparam logic [CntW:0]         DepthC = FIFO_DEPTH[CntW:0];
  localparam logic [ADDR_WIDTH-1:0] PcIncr = ADDR_WIDTH'(PC_INCR);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, rsp_pc_q;
  logic [CntW-1:0]       outstanding_q, drop_cnt_q;
  logic [CntW-1:0]       count;
  logic [CntW:0]         credit_used;
  logic [EntryW-1:0]     head;
  logic                  full, empty, push, pop, issue;

  assign pop  = if_id_write && !empty && !redirect;
  assign push = imem.rvalid && (drop_cnt_q == '0) && !redirect;

  // An entry popped this cycle frees its slot before any new grant can return a word,
  // which is what lets a depth-2 queue sustain one instruction per cycle.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, count} - {{CntW{1'b0}}, pop};
  assign imem.req    = !reset && !redirect && (credit_used < DepthC);
  assign imem.addr   = fetch_pc_q;
  assign issue       = imem.req && imem.gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if (redirect) begin
        fetch_pc_q <= redirect_pc;
        rsp_pc_q   <= redirect_pc;
        drop_cnt_q <= outstanding_q - CntW'(imem.rvalid);
      end else begin
        if (issue) fetch_pc_q <= fetch_pc_q + PcIncr;
        if (push)  rsp_pc_q   <= rsp_pc_q + PcIncr;
        if (imem.rvalid && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - CntW'(1);
      end
      outstanding_q <= outstanding_q + CntW'(issue) - CntW'(imem.rvalid);
    end
  end

  if_fetch_unit_fetch_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({rsp_pc_q, imem.rdata}),
    .pop       (pop),
    .clear     (redirect),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  assign fetch_valid = !empty;
  assign pc_out      = empty ? '0 : head[EntryW-1:INSTR_WIDTH];
  assign instr_out   = empty ? '0 : head[INSTR_WIDTH-1:0];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order memory model of selectable latency.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_write;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  int n_checks = 0;
  int n_bad    = 0;
  int lat;

  if_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) imem ();

  if_fetch_unit #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .FIFO_DEPTH  (2),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_write (if_id_write),
    .imem        (imem),
    .fetch_valid (fetch_valid),
    .pc_out      (pc_out),
    .instr_out   (instr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns ~addr, either 1 or 3 cycles after the grant; reset with the DUT.
  logic        s1, s2, s3;
  logic [31:0] a1, a2, a3;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
      a1 <= '0;   a2 <= '0;   a3 <= '0;
    end else begin
      s1 <= imem.req && imem.gnt; a1 <= imem.addr;
      s2 <= s1;                   a2 <= a1;
      s3 <= s2;                   a3 <= a2;
    end
  end
  assign imem.rvalid = (lat == 1) ? s1 : s3;
  assign imem.rdata  = (lat == 1) ? ~a1 : ~a3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    if_id_write = 1'b1;
    imem.gnt    = 1'b1;
    lat         = 1;
    #1;
    check_eq("rst_req",   imem.req,    32'd0);
    check_eq("rst_addr",  imem.addr,   32'h0);
    check_eq("rst_valid", fetch_valid, 32'd0);
    check_eq("rst_pc",    pc_out,      32'h0);
    check_eq("rst_instr", instr_out,   32'h0);
    step(); step();
    reset = 1'b0;

    // Zero-wait streaming: one entry per cycle from RESET_PC.
    #1;
    check_eq("t1_req0", imem.req, 32'd1);
    step();
    check_eq("t1_empty", fetch_valid, 32'd0);
    for (int j = 0; j < 8; j++) begin
      step();
      check_eq("t1_pc",    pc_out,      32'(4 * j));
      check_eq("t1_instr", instr_out,   ~32'(4 * j));
      check_eq("t1_valid", fetch_valid, 32'd1);
    end

    // Downstream stall: queue fills, requests stop, head frozen.
    if_id_write = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      check_eq("t2_pc",    pc_out,    32'd28);
      check_eq("t2_instr", instr_out, ~32'd28);
      check_eq("t2_req",   imem.req,  32'd0);
    end
    if_id_write = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      check_eq("t2_resume_pc", pc_out, 32'(32 + 4 * j));
    end

    // Grant withheld: request held with stable address while the queue drains.
    imem.gnt = 1'b0;
    step();
    check_eq("t3_req_a",  imem.req,    32'd1);
    check_eq("t3_addr_a", imem.addr,   32'd48);
    check_eq("t3_pc_a",   pc_out,      32'd44);
    step();
    check_eq("t3_req_b",  imem.req,    32'd1);
    check_eq("t3_addr_b", imem.addr,   32'd48);
    check_eq("t3_valid_b", fetch_valid, 32'd0);
    step();
    check_eq("t3_req_c",  imem.req,    32'd1);
    check_eq("t3_addr_c", imem.addr,   32'd48);
    check_eq("t3_valid_c", fetch_valid, 32'd0);
    check_eq("t3_nop",    instr_out,   32'h0);
    imem.gnt = 1'b1;
    step(); step();
    check_eq("t3_after_pc", pc_out,      32'd48);
    check_eq("t3_after_v",  fetch_valid, 32'd1);

    // Redirect while a word returns and the head is being consumed.
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    #1;
    check_eq("t5_noreq", imem.req, 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check_eq("t5_valid", fetch_valid, 32'd0);
    check_eq("t5_instr", instr_out,   32'h0);
    check_eq("t5_req",   imem.req,    32'd1);
    check_eq("t5_addr",  imem.addr,   32'h200);
    step();
    check_eq("t5_valid2", fetch_valid, 32'd0);
    step();
    check_eq("t5_pc",    pc_out,    32'h200);
    check_eq("t5_word",  instr_out, ~32'h200);

    // Redirect with two requests in flight on a 3-cycle memory.
    reset = 1'b1;
    lat   = 3;
    step();
    reset = 1'b0;
    #1;
    check_eq("t4_addr0", imem.addr, 32'h0);
    step(); step();
    check_eq("t4_credit", imem.req, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    #1;
    check_eq("t4_v3",   fetch_valid, 32'd0);
    check_eq("t4_req3", imem.req,    32'd0);
    step();
    check_eq("t4_v4",    fetch_valid, 32'd0);
    check_eq("t4_req4",  imem.req,    32'd1);
    check_eq("t4_addr4", imem.addr,   32'h100);
    step();
    check_eq("t4_v5",    fetch_valid, 32'd0);
    check_eq("t4_addr5", imem.addr,   32'h104);
    step();
    check_eq("t4_v6", fetch_valid, 32'd0);
    step();
    check_eq("t4_v7", fetch_valid, 32'd0);
    step();
    check_eq("t4_v8",     fetch_valid, 32'd1);
    check_eq("t4_pc8",    pc_out,      32'h100);
    check_eq("t4_instr8", instr_out,   ~32'h100);
    step();
    check_eq("t4_pc9",    pc_out,      32'h104);
    check_eq("t4_instr9", instr_out,   ~32'h104);

    // Asynchronous reset with two outstanding requests.
    step();
    check_eq("t6_addr_pre", imem.addr, 32'h110);
    reset = 1'b1;
    #1;
    check_eq("t6_req",   imem.req,    32'd0);
    check_eq("t6_addr",  imem.addr,   32'h0);
    check_eq("t6_valid", fetch_valid, 32'd0);
    check_eq("t6_pc",    pc_out,      32'h0);
    check_eq("t6_instr", instr_out,   32'h0);
    step();
    reset = 1'b0;
    #1;
    check_eq("t6_req0",  imem.req,  32'd1);
    check_eq("t6_addr0", imem.addr, 32'h0);
    step(); step();
    check_eq("t6_v2", fetch_valid, 32'd0);
    step();
    check_eq("t6_v3", fetch_valid, 32'd0);
    step();
    check_eq("t6_v4",     fetch_valid, 32'd1);
    check_eq("t6_pc4",    pc_out,      32'h0);
    check_eq("t6_instr4", instr_out,   32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
